// File: rtl/pc_pkg.sv
// Shared defaults and elaboration-time helpers for the fetch-stage program counter.
package pc_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int INSTR_BYTES_DEF = 4;

  // Low-address bits that must be zero for an instruction-aligned address.
  function automatic int unsigned align_mask(input int unsigned instr_bytes);
    return instr_bytes - 1;
  endfunction

  // Pointer width for a circular stack of the given depth (at least one bit).
  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO; a full push overwrites the oldest entry and
// push+pop in one cycle replaces the top entry in place.
module ras_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top,
  output logic [ras_ptr_w(DEPTH):0]  count
);

  localparam int PW = ras_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_top_idx;
  logic          w_pop_ok;

  // r_ptr names the next free slot, so the top lives one slot below it.
  assign w_top_idx = r_ptr - PW'(1);
  assign w_pop_ok  = pop && (r_count != '0);
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;

  always_ff @(negedge clk) begin
    if (push && w_pop_ok) begin
      r_mem[w_top_idx] <= push_data;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push && w_pop_ok) begin
      r_ptr   <= r_ptr;
      r_count <= r_count;
    end else if (push) begin
      r_ptr   <= r_ptr + PW'(1);
      r_count <= (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
    end else if (w_pop_ok) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage program counter: reset/trap vectors, stall, branch redirect and
// call/return prediction through a circular RAS. All state moves on negedge clk.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(32'h0000_0100),
  parameter int                INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           trap,
  input  logic                           br_taken,
  input  logic [ADDR_W-1:0]              br_target,
  input  logic                           call,
  input  logic                           ret,
  output logic [ADDR_W-1:0]              addr,
  output logic [ADDR_W-1:0]              next_seq,
  output logic [ras_ptr_w(RAS_DEPTH):0]  ras_count,
  output logic                           ras_empty,
  output logic                           ras_underflow,
  output logic                           misalign
);

  localparam int                CW       = ras_ptr_w(RAS_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(align_mask(INSTR_BYTES));

  if ((INSTR_BYTES < 1) || ((INSTR_BYTES & (INSTR_BYTES - 1)) != 0)) begin : g_bad_ib
    $error("pc_ctrl: INSTR_BYTES must be a power of two");
  end
  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_ctrl: RAS_DEPTH must be a power of two and at least 2");
  end
  if ((RESET_VEC & LOW_MASK) != '0) begin : g_bad_reset_vec
    $error("pc_ctrl: RESET_VEC is not instruction aligned");
  end
  if ((TRAP_VEC & LOW_MASK) != '0) begin : g_bad_trap_vec
    $error("pc_ctrl: TRAP_VEC is not instruction aligned");
  end

  logic [ADDR_W-1:0] r_addr;
  logic              r_underflow;
  logic              r_misalign;

  logic [ADDR_W-1:0] w_next_seq;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_redir;
  logic [ADDR_W-1:0] w_ras_top;
  logic [CW-1:0]     w_ras_count;
  logic              w_ras_empty;
  logic              w_tgt_mis;
  logic              w_push;
  logic              w_pop;
  logic              w_uf_nxt;
  logic              w_mis_nxt;

  assign w_next_seq  = r_addr + ADDR_W'(INSTR_BYTES);
  assign w_redir     = br_target & ~LOW_MASK;
  assign w_tgt_mis   = (br_target & LOW_MASK) != '0;
  assign w_ras_empty = (w_ras_count == '0);

  // Priority: trap > stall > ret > br_taken > sequential.
  always_comb begin
    w_addr_nxt = w_next_seq;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_uf_nxt   = 1'b0;
    w_mis_nxt  = 1'b0;
    if (trap) begin
      w_addr_nxt = TRAP_VEC;
    end else if (stall) begin
      w_addr_nxt = r_addr;
    end else if (ret && !w_ras_empty) begin
      w_addr_nxt = w_ras_top;
      w_pop      = 1'b1;
      w_push     = call;
    end else if (ret) begin
      w_addr_nxt = w_redir;
      w_uf_nxt   = 1'b1;
      w_mis_nxt  = w_tgt_mis;
      w_push     = call;
    end else if (br_taken) begin
      w_addr_nxt = w_redir;
      w_mis_nxt  = w_tgt_mis;
      w_push     = call;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_next_seq),
    .top       (w_ras_top),
    .count     (w_ras_count)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      r_addr      <= RESET_VEC;
      r_underflow <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_addr      <= w_addr_nxt;
      r_underflow <= w_uf_nxt;
      r_misalign  <= w_mis_nxt;
    end
  end

  assign addr          = r_addr;
  assign next_seq      = w_next_seq;
  assign ras_count     = w_ras_count;
  assign ras_empty     = w_ras_empty;
  assign ras_underflow = r_underflow;
  assign misalign      = r_misalign;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed scoreboard bench for pc_ctrl: the driver queues the expected state
// after each negedge; the monitor pops and checks on the following posedge.
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        trap;
  logic        br_taken;
  logic [31:0] br_target;
  logic        call;
  logic        ret;
  logic [31:0] addr;
  logic [31:0] next_seq;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_underflow;
  logic        misalign;

  pc_ctrl #(
    .ADDR_W      (32),
    .RESET_VEC   (32'h0),
    .TRAP_VEC    (32'h0000_0100),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .trap          (trap),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .call          (call),
    .ret           (ret),
    .addr          (addr),
    .next_seq      (next_seq),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_underflow (ras_underflow),
    .misalign      (misalign)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic        uf;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs settle at the negedge, so check at the posedge after it.
  always @(posedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (addr !== e.addr || ras_count !== e.cnt || ras_underflow !== e.uf ||
          misalign !== e.mis || ras_empty !== (e.cnt == 3'd0) ||
          next_seq !== e.addr + 32'd4) begin
        n_fail++;
        $display("FAIL %s: got addr=%h next=%h cnt=%0d empty=%b uf=%b mis=%b, want addr=%h next=%h cnt=%0d empty=%b uf=%b mis=%b",
                 e.name, addr, next_seq, ras_count, ras_empty, ras_underflow, misalign,
                 e.addr, e.addr + 32'd4, e.cnt, (e.cnt == 3'd0), e.uf, e.mis);
      end
    end
  end

  task automatic step(input string nm, input logic i_rst, input logic i_stall,
                      input logic i_trap, input logic i_br, input logic [31:0] i_tgt,
                      input logic i_call, input logic i_ret,
                      input logic [31:0] e_addr, input logic [2:0] e_cnt,
                      input logic e_uf, input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = i_rst;
    stall     = i_stall;
    trap      = i_trap;
    br_taken  = i_br;
    br_target = i_tgt;
    call      = i_call;
    ret       = i_ret;
    e.name = nm; e.addr = e_addr; e.cnt = e_cnt; e.uf = e_uf; e.mis = e_mis;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; trap = 1'b0; br_taken = 1'b0;
    br_target = '0; call = 1'b0; ret = 1'b0;

    //            name          rst stl trp br  target        cl rt  addr          cnt uf mis
    step("reset",      1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
    step("seq1",       0, 0, 0, 0, 32'h0,         0, 0, 32'h4,         0, 0, 0);
    step("seq2",       0, 0, 0, 0, 32'h0,         0, 0, 32'h8,         0, 0, 0);
    step("seq3",       0, 0, 0, 0, 32'h0,         0, 0, 32'hC,         0, 0, 0);
    step("seq4",       0, 0, 0, 0, 32'h0,         0, 0, 32'h10,        0, 0, 0);
    step("stall1",     0, 1, 0, 0, 32'h0,         0, 0, 32'h10,        0, 0, 0);
    step("stall2",     0, 1, 0, 0, 32'h0,         0, 0, 32'h10,        0, 0, 0);
    step("trap_stall", 0, 1, 1, 0, 32'h0,         0, 0, 32'h100,       0, 0, 0);
    step("br40",       0, 0, 0, 1, 32'h40,        0, 0, 32'h40,        0, 0, 0);
    step("call200",    0, 0, 0, 1, 32'h200,       1, 0, 32'h200,       1, 0, 0);
    step("seq204",     0, 0, 0, 0, 32'h0,         0, 0, 32'h204,       1, 0, 0);
    step("seq208",     0, 0, 0, 0, 32'h0,         0, 0, 32'h208,       1, 0, 0);
    step("ret44",      0, 0, 0, 0, 32'h0,         0, 1, 32'h44,        0, 0, 0);
    step("br0",        0, 0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 0);
    step("callA",      0, 0, 0, 1, 32'h100,       1, 0, 32'h100,       1, 0, 0);
    step("callB",      0, 0, 0, 1, 32'h200,       1, 0, 32'h200,       2, 0, 0);
    step("callC",      0, 0, 0, 1, 32'h300,       1, 0, 32'h300,       3, 0, 0);
    step("callD",      0, 0, 0, 1, 32'h400,       1, 0, 32'h400,       4, 0, 0);
    step("callE_full", 0, 0, 0, 1, 32'h500,       1, 0, 32'h500,       4, 0, 0);
    step("ret404",     0, 0, 0, 0, 32'h0,         0, 1, 32'h404,       3, 0, 0);
    step("ret304",     0, 0, 0, 0, 32'h0,         0, 1, 32'h304,       2, 0, 0);
    step("ret204",     0, 0, 0, 0, 32'h0,         0, 1, 32'h204,       1, 0, 0);
    step("ret104",     0, 0, 0, 0, 32'h0,         0, 1, 32'h104,       0, 0, 0);
    step("ret_under",  0, 0, 0, 0, 32'h80,        0, 1, 32'h80,        0, 1, 0);
    step("uf_clear",   0, 0, 0, 0, 32'h0,         0, 0, 32'h84,        0, 0, 0);
    step("br_mis",     0, 0, 0, 1, 32'h123,       0, 0, 32'h120,       0, 0, 1);
    step("mis_clear",  0, 0, 0, 0, 32'h0,         0, 0, 32'h124,       0, 0, 0);
    step("br_top",     0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    step("wrap",       0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
    step("call400",    0, 0, 0, 1, 32'h400,       1, 0, 32'h400,       1, 0, 0);
    step("br500",      0, 0, 0, 1, 32'h500,       0, 0, 32'h500,       1, 0, 0);
    step("call600",    0, 0, 0, 1, 32'h600,       1, 0, 32'h600,       2, 0, 0);
    step("call_ret",   0, 0, 0, 1, 32'h0,         1, 1, 32'h504,       2, 0, 0);
    step("ret604",     0, 0, 0, 0, 32'h0,         0, 1, 32'h604,       1, 0, 0);
    step("ret4",       0, 0, 0, 0, 32'h0,         0, 1, 32'h4,         0, 0, 0);
    step("call700",    0, 0, 0, 1, 32'h700,       1, 0, 32'h700,       1, 0, 0);
    step("trap_ras",   0, 0, 1, 0, 32'h0,         0, 0, 32'h100,       1, 0, 0);
    step("br_mis2",    0, 0, 0, 1, 32'h201,       0, 0, 32'h200,       1, 0, 1);
    step("stall_clr",  0, 1, 0, 0, 32'h0,         0, 0, 32'h200,       1, 0, 0);
    step("rst_stall",  1, 1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 0);
    step("post_rst",   0, 0, 0, 0, 32'h0,         0, 0, 32'h4,         0, 0, 0);

    @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b0; trap = 1'b0; br_taken = 1'b0; call = 1'b0; ret = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised next-generation program counter for the fetch stage. It holds the current fetch address and updates it on the falling edge of clk.
- Adds synchronous reset to a configurable vector, stall/hold, branch redirect, and a trap vector.
- Adds a circular return-address stack (RAS) for call/return prediction.
- Flags misaligned targets and RAS underflow.

Parameters:
ADDR_W, 32, address width in bits
RESET_VEC, 0, address loaded on reset
TRAP_VEC, 32'h0000_0100, address loaded on trap
INSTR_BYTES, 4, sequential increment; power of two
RAS_DEPTH, 4, return-address stack entries; power of two, ≥2

Ports:
clk  in  1  clock; all state updates on negedge clk
rst  in  1  synchronous active-high reset, sampled on negedge clk
stall  in  1  hold addr and RAS unchanged
trap  in  1  redirect to TRAP_VEC
br_taken  in  1  redirect to br_target
br_target  in  ADDR_W  branch/jump target
call  in  1  push return address (addr+INSTR_BYTES); valid only with br_taken
ret  in  1  redirect to RAS top and pop
addr  out  ADDR_W  current fetch address (registered)
next_seq  out  ADDR_W  addr+INSTR_BYTES, combinational, modulo 2^ADDR_W
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_empty  out  1  ras_count==0
ras_underflow  out  1  registered one-cycle pulse
misalign  out  1  registered one-cycle pulse

Behaviour:
- Reset (negedge with rst=1):
  - addr=RESET_VEC, ras_count=0, RAS pointer=0, ras_underflow=0, misalign=0.
  - RAS contents are don't-care.
  - Reset overrides everything, including mid-stall or mid-call.
- Update priority each negedge when rst=0: trap > stall > ret > br_taken > sequential.
  - trap: addr=TRAP_VEC. RAS is untouched. trap overrides stall.
  - stall (no trap): addr, RAS and ras_count are held. Both flags clear to 0.
  - ret with ras_count>0:
    - addr = RAS top.
    - If call=1 in the same cycle, the top entry is overwritten with next_seq and ras_count is unchanged.
    - Otherwise the stack pops and ras_count is decremented.
  - ret with ras_count==0:
    - addr=br_target (fallback), ras_underflow=1 for one cycle. No pop.
    - A simultaneous call then pushes normally.
  - br_taken (no ret): addr=br_target.
    - If call=1, push next_seq: pointer advances, ras_count = min(ras_count+1, RAS_DEPTH).
    - On a full push the oldest entry is overwritten (circular).
  - call without br_taken or ret: ignored.
  - Sequential: addr = addr+INSTR_BYTES, wrapping at 2^ADDR_W.
- Alignment:
  - Any redirect target (br_target, fallback) with non-zero low log2(INSTR_BYTES) bits is loaded with those bits cleared.
  - misalign=1 for the following cycle.
  - TRAP_VEC and RESET_VEC must be aligned; this is checked at elaboration.
- Flags are registered, default 0, and valid for exactly one cycle after the causing edge.
- Latency: one negedge from input to addr.
- next_seq tracks addr combinationally.

Decomposition:
- Shared package pc_pkg: ADDR_W default, INSTR_BYTES default, the alignment-mask function, and the RAS pointer width function.
- Sub-module ras_stack (circular LIFO): parameters DEPTH, W; ports push, pop, push_data, top, count. It implements replace-top when push and pop coincide.

Test Plan:
- Reset and sequential fetch: rst=1 for one cycle, then 3 idle cycles → addr 0x0, 0x4, 0x8, 0xC; ras_empty=1.
- Stall vs trap: stall=1 at addr 0x10 for 2 cycles → addr holds 0x10. Then stall=1 with trap=1 → addr=0x100.
- Call/return: br_taken+call, target 0x200, at addr 0x40 → addr=0x200, ras_count=1. After 2 sequential cycles, ret → addr=0x44, ras_count=0.
- RAS overflow and underflow:
  - 5 calls with DEPTH=4 from 0x0, 0x100, 0x200, 0x300, 0x400 → ras_count=4. Four rets return 0x404, 0x304, 0x204, 0x104.
  - A fifth ret with br_target=0x80 → addr=0x80, ras_underflow=1 for one cycle.
- Misaligned and wrap:
  - br_taken with target 0x123 → addr=0x120, misalign=1 next cycle only.
  - Sequential from 0xFFFF_FFFC → addr=0x0.
- Simultaneous call+ret and reset mid-operation:
  - ras_count=2, top=0x504, addr=0x600, call+ret → addr=0x504, ras_count=2, new top=0x604.
  - rst asserted with stall=1 → addr=RESET_VEC, ras_count=0.
